trace_packer: RTL and testbench

Upstream feeder of the TraceLogger. Accepts narrow trace samples from the traced design and packs them LSB-first into TRB_WIDTH-bit words. Presents each completed word to the logger's DATA_I/STORE_I/STORE_PERM_O interface. Tags the word that holds the first trigger sample, driving the logger's TRG_EVENT_I and EVENT_POS_I.

---
 rtl/trace_packer_if.sv | 43 ++++
 rtl/trace_packer.sv | 131 +++++++++++++
 tb/tb_trace_packer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_packer_if.sv
// rtl/trace_packer_if.sv - sample-in / packed-word-out bundle for trace_packer
//
// Purpose: groups the trace sample inputs and the logger-facing word port.
//   master : the traced design plus logger side (drives samples, store_perm)
//   slave  : the packer (drives data, store, trg_event, event_pos, overflow)
// Signals:
//   ntrace     log2 of sample width (0..log2(TRB_WIDTH))
//   valid      sample valid this cycle
//   trace      sample data, low 2**ntrace bits used
//   trg        trigger qualifier for the current sample
//   flush      close the current partial word, zero-filling the rest
//   data       packed word (logger DATA_I)
//   store      word transfer strobe (logger STORE_I)
//   store_perm logger permission (logger STORE_PERM_O)
//   trg_event  stored word carries the trigger (logger TRG_EVENT_I)
//   event_pos  bit offset of the trigger sample in data (logger EVENT_POS_I)
//   overflow   sticky: at least one sample was dropped
interface trace_packer_if #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_NTRACE_BITS = 3
);
  logic [TRB_NTRACE_BITS-1:0]   ntrace;
  logic                         valid;
  logic [TRB_WIDTH-1:0]         trace;
  logic                         trg;
  logic                         flush;
  logic [TRB_WIDTH-1:0]         data;
  logic                         store;
  logic                         store_perm;
  logic                         trg_event;
  logic [$clog2(TRB_WIDTH)-1:0] event_pos;
  logic                         overflow;

  modport master (
    output ntrace, valid, trace, trg, flush, store_perm,
    input  data, store, trg_event, event_pos, overflow
  );

  modport slave (
    input  ntrace, valid, trace, trg, flush, store_perm,
    output data, store, trg_event, event_pos, overflow
  );
endinterface

// File: rtl/trace_packer.sv
// rtl/trace_packer.sv - packs narrow trace samples LSB-first into logger words
//
// Purpose: accumulates 2**ntrace-bit samples into TRB_WIDTH-bit words and
// hands completed words to the TraceLogger, tagging the word that holds the
// first trigger sample.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    trace_packer_if.slave (sample inputs, logger word port)
// Storage: accumulator (acc/pos/acc_full) feeding a holding register
// (hold/hv) that the logger drains while store_perm is high.
module trace_packer #(
  parameter int TRB_WIDTH       = 64,
  parameter int TRB_NTRACE_BITS = 3
) (
  input logic           clk,
  input logic           rst_n,
  trace_packer_if.slave bus
);
  localparam int LOG2W = $clog2(TRB_WIDTH);
  localparam int PW    = LOG2W + 1;

  logic [TRB_WIDTH-1:0]       acc, hold;
  logic [LOG2W-1:0]           pos, acc_tpos, hold_tpos;
  logic                       acc_full, acc_tag, hv, hold_tag, trg_pend, overflow;
  logic [TRB_NTRACE_BITS-1:0] nt_q;

  logic                       store, hold_free, transfer, room, accept, drop;
  logic                       trg_now, complete, direct;
  logic [TRB_WIDTH-1:0]       base_acc, mask, next_acc;
  logic [LOG2W-1:0]           base_pos, base_tpos, next_tpos;
  logic                       base_tag, next_tag;
  logic [TRB_NTRACE_BITS-1:0] nt_in, cur_nt;
  logic [PW-1:0]              w, sh, sum;

  assign store = hv & bus.store_perm;

  always_comb begin
    nt_in     = (bus.ntrace > TRB_NTRACE_BITS'(LOG2W)) ? TRB_NTRACE_BITS'(LOG2W) : bus.ntrace;
    hold_free = ~hv | store;
    transfer  = acc_full & hold_free;
    // After a transfer the accumulator is empty for a sample on the same edge.
    base_acc  = transfer ? '0 : acc;
    base_pos  = transfer ? '0 : pos;
    base_tag  = transfer ? 1'b0 : acc_tag;
    base_tpos = transfer ? '0 : acc_tpos;
    room      = ~acc_full | transfer;
    accept    = bus.valid & room;
    drop      = bus.valid & ~room;
    // Width is only taken from the input at the start of a word.
    cur_nt    = (base_pos == '0) ? nt_in : nt_q;
    w         = PW'(1) << cur_nt;
    sh        = PW'(TRB_WIDTH) - w;
    mask      = {TRB_WIDTH{1'b1}} >> sh;
    trg_now   = (bus.valid & bus.trg) | trg_pend;
    next_acc  = base_acc;
    sum       = {1'b0, base_pos};
    next_tag  = base_tag;
    next_tpos = base_tpos;
    if (accept) begin
      next_acc = base_acc | ((bus.trace & mask) << base_pos);
      sum      = {1'b0, base_pos} + w;
      if (trg_now && !base_tag) begin
        next_tag  = 1'b1;
        next_tpos = base_pos;
      end
    end
    // Flush only closes a non-empty, not-yet-full word (judged before the edge).
    complete = (accept && sum == PW'(TRB_WIDTH)) ||
               (bus.flush && !acc_full && pos != '0);
    // A word completing while the holding register is free skips the
    // accumulator-full stage, so STORE can follow in the very next cycle.
    direct   = complete & ~acc_full & hold_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      pos       <= '0;
      acc_full  <= 1'b0;
      acc_tag   <= 1'b0;
      acc_tpos  <= '0;
      hold      <= '0;
      hv        <= 1'b0;
      hold_tag  <= 1'b0;
      hold_tpos <= '0;
      trg_pend  <= 1'b0;
      overflow  <= 1'b0;
      nt_q      <= '0;
    end else begin
      overflow <= overflow | drop;
      if (accept)              trg_pend <= 1'b0;
      else if (drop & bus.trg) trg_pend <= 1'b1;
      if (accept && base_pos == '0) nt_q <= cur_nt;

      if (direct) begin
        acc      <= '0;
        pos      <= '0;
        acc_full <= 1'b0;
        acc_tag  <= 1'b0;
        acc_tpos <= '0;
      end else begin
        acc      <= next_acc;
        pos      <= complete ? '0 : sum[LOG2W-1:0];
        acc_full <= complete | (acc_full & ~transfer);
        acc_tag  <= next_tag;
        acc_tpos <= next_tpos;
      end

      if (direct) begin
        hold      <= next_acc;
        hv        <= 1'b1;
        hold_tag  <= next_tag;
        hold_tpos <= next_tpos;
      end else if (transfer) begin
        hold      <= acc;
        hv        <= 1'b1;
        hold_tag  <= acc_tag;
        hold_tpos <= acc_tpos;
      end else if (store) begin
        hv <= 1'b0;
      end
    end
  end

  assign bus.data      = hold;
  assign bus.store     = store;
  assign bus.trg_event = store & hold_tag;
  assign bus.event_pos = hold_tag ? hold_tpos : '0;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_trace_packer.sv
// tb/tb_trace_packer.sv - self-checking bench for trace_packer
module tb_trace_packer;
  localparam int TW = 64;
  localparam int NB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_packer_if #(.TRB_WIDTH(TW), .TRB_NTRACE_BITS(NB)) bus ();
  trace_packer #(.TRB_WIDTH(TW), .TRB_NTRACE_BITS(NB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        t;
    logic        f;
    logic [2:0]  nt;
    logic        p;
    logic        es;
    logic [63:0] ed;
    logic        ete;
    logic [5:0]  ep;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    logic [63:0] d;
    bit          tag;
    int          tp;
  } word_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic t,
                       input logic f, input logic [2:0] nt, input logic p);
    bus.valid      = v;
    bus.trace      = d;
    bus.trg        = t;
    bus.flush      = f;
    bus.ntrace     = nt;
    bus.store_perm = p;
  endtask

  task automatic add(input logic v, input logic [63:0] d, input logic t, input logic f,
                     input logic [2:0] nt, input logic p, input logic es,
                     input logic [63:0] ed, input logic ete, input logic [5:0] ep);
    vec_t r;
    r.v = v; r.d = d; r.t = t; r.f = f; r.nt = nt; r.p = p;
    r.es = es; r.ed = ed; r.ete = ete; r.ep = ep;
    tbl.push_back(r);
  endtask

  // Reference model: a partial word plus a FIFO of at most two finished words.
  logic [63:0] m_bits;
  int          m_pos, m_w, m_tpos;
  bit          m_tag, m_pend, m_ovf;
  word_t       m_q[$];

  task automatic m_close;
    word_t wd;
    wd.d = m_bits; wd.tag = m_tag; wd.tp = m_tpos;
    m_q.push_back(wd);
    m_bits = '0; m_pos = 0; m_tag = 0; m_tpos = 0;
  endtask

  task automatic m_edge(input logic v, input logic [63:0] d, input logic t,
                        input logic f, input logic [2:0] nt, input bit popped);
    int pre_pos;
    pre_pos = m_pos;
    if (popped) void'(m_q.pop_front());
    if (v) begin
      if (m_q.size() < 2) begin
        if (m_pos == 0) m_w = 1 << nt;
        for (int b = 0; b < m_w; b++) m_bits[m_pos + b] = d[b];
        if ((t || m_pend) && !m_tag) begin
          m_tag = 1; m_tpos = m_pos;
        end
        m_pend = 0;
        m_pos += m_w;
        if (m_pos == TW) m_close();
      end else begin
        m_ovf = 1;
        if (t) m_pend = 1;
      end
    end
    if (f && pre_pos > 0 && m_pos > 0) m_close();
  endtask

  initial begin
    logic [63:0] d, prev;
    logic [63:0] w1, w2;
    logic        v, t, f, p;
    logic [2:0]  nt;
    bit          es;

    // reset state
    drive(0, '0, 0, 0, 3'd3, 1);
    #12;
    chk("rst_store", bus.store, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_trg_event", bus.trg_event, 0);
    chk("rst_event_pos", bus.event_pos, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst_n = 1'b1;
    tick();

    // table: plain word, triggered word, flushed word, word after flush
    for (int i = 1; i <= 8; i++) add(1, 64'(i), 0, 0, 3'd3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3'd3, 1, 1, 64'h0807060504030201, 0, 0);
    for (int i = 1; i <= 8; i++) add(1, 64'(i), (i == 3 || i == 6), 0, 3'd3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3'd3, 1, 1, 64'h0807060504030201, 1, 6'd16);
    add(1, 64'hAA, 0, 0, 3'd3, 1, 0, 0, 0, 0);
    add(1, 64'hBB, 0, 0, 3'd3, 1, 0, 0, 0, 0);
    add(1, 64'hCC, 0, 0, 3'd3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 3'd3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3'd3, 1, 1, 64'h0000000000CCBBAA, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 64'(8'h11 + i), 0, 0, 3'd3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3'd3, 1, 1, 64'h1817161514131211, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].t, tbl[i].f, tbl[i].nt, tbl[i].p);
      #1;
      chk($sformatf("tbl%0d_store", i), bus.store, tbl[i].es);
      chk($sformatf("tbl%0d_trg_event", i), bus.trg_event, tbl[i].ete);
      if (tbl[i].es) begin
        chk($sformatf("tbl%0d_data", i), bus.data, tbl[i].ed);
        chk($sformatf("tbl%0d_event_pos", i), bus.event_pos, tbl[i].ep);
      end
      tick();
    end

    // two words buffered with no permission, 17th sample dropped
    for (int i = 1; i <= 17; i++) begin
      drive(1, 64'(i), 0, 0, 3'd3, 0);
      #1;
      if (i == 17) chk("ovf_before_drop", bus.overflow, 0);
      tick();
    end
    drive(0, 0, 0, 0, 3'd3, 0);
    #1;
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_noperm_store", bus.store, 0);
    tick();
    drive(0, 0, 0, 0, 3'd3, 1);
    #1;
    chk("ovf_store1", bus.store, 1);
    chk("ovf_data1", bus.data, 64'h0807060504030201);
    tick();
    #1;
    chk("ovf_store2", bus.store, 1);
    chk("ovf_data2", bus.data, 64'h100F0E0D0C0B0A09);
    tick();
    #1;
    chk("ovf_no_third", bus.store, 0);
    chk("ovf_sticky", bus.overflow, 1);
    tick();

    // 1-bit samples, then full-width samples back to back
    for (int i = 0; i < 64; i++) begin
      drive(1, 64'((i + 1) % 2), 0, 0, 3'd0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 3'd0, 1);
    #1;
    chk("bit_store", bus.store, 1);
    chk("bit_data", bus.data, 64'h5555555555555555);
    tick();
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom};
      drive(1, d, 0, 0, 3'd6, 1);
      #1;
      if (i > 0) begin
        chk($sformatf("wide%0d_store", i), bus.store, 1);
        chk($sformatf("wide%0d_data", i), bus.data, prev);
      end
      prev = d;
      tick();
    end
    drive(0, 0, 0, 0, 3'd3, 1);
    #1;
    chk("wide_last_data", bus.data, prev);
    tick();

    // asynchronous reset with a held word and a half-filled accumulator
    for (int i = 0; i < 12; i++) begin
      drive(1, 64'(8'h40 + i), 0, 0, 3'd3, 0);
      tick();
    end
    drive(0, 0, 0, 0, 3'd3, 1);
    #1;
    chk("prerst_store", bus.store, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_store", bus.store, 0);
    chk("midrst_overflow", bus.overflow, 0);
    chk("midrst_data", bus.data, 0);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1, 64'(8'h21 + i), 0, 0, 3'd3, 1);
      #1;
      chk($sformatf("postrst%0d_store", i), bus.store, 0);
      tick();
    end
    drive(0, 0, 0, 0, 3'd3, 1);
    #1;
    chk("postrst_store", bus.store, 1);
    chk("postrst_data", bus.data, 64'h2827262524232221);
    tick();

    // randomized run against the reference model
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_bits = '0; m_pos = 0; m_w = 1; m_tpos = 0; m_tag = 0; m_pend = 0; m_ovf = 0;
    m_q.delete();
    nt = 3'd3;
    tick();
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 9) < 7);
      d = {$urandom, $urandom};
      t = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 15) == 0) nt = 3'($urandom_range(0, 6));
      drive(v, d, t, f, nt, p);
      #1;
      es = (m_q.size() > 0) && p;
      chk($sformatf("rnd%0d_store", c), bus.store, es);
      chk($sformatf("rnd%0d_overflow", c), bus.overflow, m_ovf);
      if (es) begin
        w1 = m_q[0].d;
        w2 = m_q[0].tag ? 64'(m_q[0].tp) : 64'd0;
        chk($sformatf("rnd%0d_data", c), bus.data, w1);
        chk($sformatf("rnd%0d_trg_event", c), bus.trg_event, m_q[0].tag);
        chk($sformatf("rnd%0d_event_pos", c), bus.event_pos, w2);
      end else begin
        chk($sformatf("rnd%0d_trg_event", c), bus.trg_event, 0);
      end
      m_edge(v, d, t, f, nt, es);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
